// File: rtl/smg_arbmod.sv
// smg_arbmod: two-requester display scheduler in front of the 6-digit
// seven-segment base module. A granted requester keeps the display for at
// least T_HOLD cycles. After that the display passes round-robin to the other
// requester, or is released when nobody else wants it.
module smg_arbmod #(
   parameter int unsigned T_HOLD = 50_000_000,
   parameter int unsigned CW     = 26
) (
   input  logic        CLOCK,
   input  logic        RESET,
   input  logic [1:0]  iReq,
   input  logic [23:0] iData0,
   input  logic [23:0] iData1,
   output logic [23:0] oData,
   output logic [1:0]  oGrant,
   output logic        oSwitch
);

   typedef enum logic {IDLE, SHOW} state_t;

   // The hold counter saturates here. This value also marks expiry.
   localparam logic [CW-1:0] HOLD_MAX = CW'(T_HOLD - 1);

   state_t        state, state_nxt;
   logic          owner, owner_nxt;   // index of the current owner, valid in SHOW
   logic          last, last_nxt;     // index of the previous owner, used for tie-break
   logic [CW-1:0] count, count_nxt;
   logic [23:0]   data, data_nxt;
   logic          sw, sw_nxt;

   logic          req_own, req_other;
   logic [23:0]   own_data, other_data;

   assign req_own    = iReq[owner];
   assign req_other  = iReq[~owner];
   assign own_data   = owner ? iData1 : iData0;
   assign other_data = owner ? iData0 : iData1;

   // State register: all scheduler state, with a synchronous active-low reset.
   always_ff @(posedge CLOCK) begin
      // NOTE: sequential state uses non-blocking assignments. Every register
      // then samples values from before the edge, with no race between them.
      if (!RESET) begin
         state <= IDLE;
         owner <= 1'b0;
         last  <= 1'b1;
         count <= '0;
         data  <= '0;
         sw    <= 1'b0;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
         last  <= last_nxt;
         count <= count_nxt;
         data  <= data_nxt;
         sw    <= sw_nxt;
      end
   end

   // Next-state logic: grant, hold, hand-over and release decisions.
   always_comb begin
      // NOTE: every signal gets a default first. No path through the case
      // can then leave one unassigned, so no latch is inferred.
      state_nxt = state;
      owner_nxt = owner;
      last_nxt  = last;
      count_nxt = count;
      data_nxt  = data;
      sw_nxt    = 1'b0;
      unique case (state)
         IDLE: begin
            if (iReq != 2'b00) begin
               state_nxt = SHOW;
               sw_nxt    = 1'b1;
               count_nxt = '0;
               // On a tie the grant goes to the requester that was not the
               // previous owner. Otherwise it goes to the only requester.
               owner_nxt = (iReq == 2'b11) ? ~last : iReq[1];
            end
         end
         SHOW: begin
            if (count == HOLD_MAX) begin
               if (req_other) begin
                  owner_nxt = ~owner;
                  last_nxt  = owner;
                  sw_nxt    = 1'b1;
                  count_nxt = '0;
                  data_nxt  = other_data;
               end else if (!req_own) begin
                  state_nxt = IDLE;
                  last_nxt  = owner;
               end else begin
                  data_nxt  = own_data;
               end
            end else begin
               count_nxt = count + CW'(1);
               if (req_own) data_nxt = own_data;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode: every output comes from a register, so no input reaches
   // an output combinationally.
   always_comb begin
      oGrant  = (state == SHOW) ? (owner ? 2'b10 : 2'b01) : 2'b00;
      oData   = data;
      oSwitch = sw;
   end

endmodule

// File: tb/tb_smg_arbmod.sv
// tb_smg_arbmod: directed self-checking bench for smg_arbmod. The main
// instance uses T_HOLD=4. A second instance uses T_HOLD=1, driven by the same
// inputs, to cover per-cycle alternation.
module tb_smg_arbmod;

   logic        CLOCK;
   logic        RESET;
   logic [1:0]  iReq;
   logic [23:0] iData0, iData1;
   logic [23:0] oData,  oData_1;
   logic [1:0]  oGrant, oGrant_1;
   logic        oSwitch, oSwitch_1;

   int total = 0;
   int bad   = 0;

   smg_arbmod #(.T_HOLD(4), .CW(3)) u_dut (
      .CLOCK(CLOCK), .RESET(RESET), .iReq(iReq),
      .iData0(iData0), .iData1(iData1),
      .oData(oData), .oGrant(oGrant), .oSwitch(oSwitch)
   );

   smg_arbmod #(.T_HOLD(1), .CW(1)) u_dut1 (
      .CLOCK(CLOCK), .RESET(RESET), .iReq(iReq),
      .iData0(iData0), .iData1(iData1),
      .oData(oData_1), .oGrant(oGrant_1), .oSwitch(oSwitch_1)
   );

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [1:0] g, input logic s, input logic [23:0] d);
      chk({tag, ".grant"},  32'(oGrant),  32'(g));
      chk({tag, ".switch"}, 32'(oSwitch), 32'(s));
      chk({tag, ".data"},   32'(oData),   32'(d));
   endtask

   task automatic do_reset();
      RESET = 1'b0;
      iReq  = 2'b00;
      tick();
      tick();
      RESET = 1'b1;
   endtask

   // Expected outputs for edges 1..9 under a constant 11 request with T_HOLD=4.
   logic [1:0]  e3_g [9] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
   logic        e3_s [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
   logic [23:0] e3_d [9] = '{24'h000000, 24'h111111, 24'h111111, 24'h111111, 24'h222222,
                             24'h222222, 24'h222222, 24'h222222, 24'h111111};
   // The same edges for T_HOLD=1, where ownership alternates every cycle.
   logic [1:0]  e1_g [3] = '{2'b01, 2'b10, 2'b01};
   logic [23:0] e1_d [3] = '{24'h000000, 24'h222222, 24'h111111};

   initial begin
      int pulses;
      RESET  = 1'b0;
      iReq   = 2'b11;
      iData0 = '0;
      iData1 = '0;

      // Reset held with both requesting: outputs stay cleared.
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_out($sformatf("rst%0d", i), 2'b00, 1'b0, 24'h000000);
      end
      RESET = 1'b1;
      tick();
      chk_out("rst_release", 2'b01, 1'b1, 24'h000000);

      // Single requester 0: grant first, then the data tracks one cycle late.
      do_reset();
      iReq   = 2'b01;
      iData0 = 24'h123456;
      tick();
      chk_out("single_grant", 2'b01, 1'b1, 24'h000000);
      tick();
      chk_out("single_data", 2'b01, 1'b0, 24'h123456);
      iData0 = 24'h654321;
      tick();
      chk_out("single_track", 2'b01, 1'b0, 24'h654321);

      // Constant contention: strict alternation every 4 cycles (and every
      // cycle for T_HOLD=1).
      do_reset();
      iReq   = 2'b11;
      iData0 = 24'h111111;
      iData1 = 24'h222222;
      for (int k = 0; k < 9; k++) begin
         tick();
         chk_out($sformatf("alt%0d", k + 1), e3_g[k], e3_s[k], e3_d[k]);
         if (k < 3) begin
            chk($sformatf("th1_grant%0d", k + 1), 32'(oGrant_1), 32'(e1_g[k]));
            chk($sformatf("th1_switch%0d", k + 1), 32'(oSwitch_1), 32'(1'b1));
            chk($sformatf("th1_data%0d", k + 1), 32'(oData_1), 32'(e1_d[k]));
         end
      end

      // The owner drops its request early: the hold is kept, then the display
      // is released with the data frozen.
      do_reset();
      iReq   = 2'b01;
      iData0 = 24'h135790;
      tick();
      chk_out("drop_grant", 2'b01, 1'b1, 24'h000000);
      tick();
      chk_out("drop_c1", 2'b01, 1'b0, 24'h135790);
      iReq   = 2'b00;
      iData0 = 24'h999999;
      tick();
      chk_out("drop_c2", 2'b01, 1'b0, 24'h135790);
      tick();
      chk_out("drop_c3", 2'b01, 1'b0, 24'h135790);
      tick();
      chk_out("drop_idle", 2'b00, 1'b0, 24'h135790);
      // Last is now 0, so a tie goes to requester 1.
      iReq = 2'b11;
      tick();
      chk_out("tie_after_idle", 2'b10, 1'b1, 24'h135790);

      // Sole requester 1 keeps the display, then gives it up immediately
      // because the counter is already saturated.
      do_reset();
      iReq   = 2'b10;
      iData0 = 24'h111111;
      iData1 = 24'h246802;
      pulses = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         chk($sformatf("solo_grant%0d", k), 32'(oGrant), 32'(2'b10));
         if (oSwitch) pulses++;
      end
      chk("solo_pulses", 32'(pulses), 32'd1);
      chk("solo_data", 32'(oData), 32'h246802);
      iReq = 2'b11;
      tick();
      chk_out("solo_handover", 2'b01, 1'b1, 24'h111111);

      // Reset mid-SHOW while requester 1 owns the display with Count=2 and
      // Last=0. The restart must still favour requester 0.
      do_reset();
      iReq   = 2'b11;
      iData0 = 24'h111111;
      iData1 = 24'h222222;
      for (int k = 0; k < 7; k++) tick();
      chk_out("mid_owner1", 2'b10, 1'b0, 24'h222222);
      RESET = 1'b0;
      tick();
      chk_out("mid_reset", 2'b00, 1'b0, 24'h000000);
      RESET = 1'b1;
      tick();
      chk_out("mid_regrant", 2'b01, 1'b1, 24'h000000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
